// File: rtl/ofm_drain_streamer.sv
// Drains one frame from OFM RAM port B and streams the unpacked signed elements over valid/ready.
// Build macro OFM_DRAIN_RELU_EN: clamp negative elements to zero as each word is loaded.
module ofm_drain_streamer #(
    parameter int INOUT_WIDTH = 128,
    parameter int ELEM_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 11,
    parameter int FRAME_WORDS = 2048,
    parameter int ROW_ELEMS   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    output logic                   ofm_re_b,
    output logic [ADDR_WIDTH-1:0]  ofm_addr_b,
    input  logic [INOUT_WIDTH-1:0] ofm_dout_b,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ELEM_WIDTH-1:0]  m_data,
    output logic                   m_last_row,
    output logic                   m_last_frame,
    output logic                   busy,
    output logic                   done
);
    localparam int EPW    = INOUT_WIDTH / ELEM_WIDTH;
    localparam int EIDX_W = (EPW > 1) ? $clog2(EPW) : 1;
    localparam int ROW_W  = (ROW_ELEMS > 1) ? $clog2(ROW_ELEMS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam logic [EIDX_W-1:0]     LAST_ELEM = EIDX_W'(EPW - 1);
    localparam logic [ROW_W-1:0]      LAST_COL  = ROW_W'(ROW_ELEMS - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_EMIT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [ADDR_WIDTH-1:0]  word_q, word_d;
    logic [EIDX_W-1:0]      elem_q, elem_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [INOUT_WIDTH-1:0] shreg_q, shreg_d;

    function automatic logic [INOUT_WIDTH-1:0] load_word(input logic [INOUT_WIDTH-1:0] w);
        logic [INOUT_WIDTH-1:0] r;
        r = w;
`ifdef OFM_DRAIN_RELU_EN
        for (int i = 0; i < EPW; i++) begin
            if (w[i*ELEM_WIDTH + ELEM_WIDTH - 1]) r[i*ELEM_WIDTH +: ELEM_WIDTH] = '0;
        end
`endif
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            word_q  <= '0;
            elem_q  <= '0;
            row_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            word_q  <= word_d;
            elem_q  <= elem_d;
            row_q   <= row_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        word_d       = word_q;
        elem_d       = elem_q;
        row_d        = row_q;
        shreg_d      = shreg_q;
        ofm_re_b     = 1'b0;
        ofm_addr_b   = '0;
        m_valid      = 1'b0;
        m_data       = '0;
        m_last_row   = 1'b0;
        m_last_frame = 1'b0;
        busy         = (state_q != S_IDLE);
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    word_d  = '0;
                    elem_d  = '0;
                    row_d   = '0;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                // Address wraps naturally at ADDR_WIDTH bits.
                ofm_re_b   = 1'b1;
                ofm_addr_b = base_q + word_q;
                state_d    = S_LAT;
            end
            S_LAT: begin
                shreg_d = load_word(ofm_dout_b);
                elem_d  = '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                m_valid      = 1'b1;
                m_data       = shreg_q[ELEM_WIDTH-1:0];
                m_last_row   = (row_q == LAST_COL);
                m_last_frame = (word_q == LAST_WORD) && (elem_q == LAST_ELEM);
                if (m_ready) begin
                    shreg_d = shreg_q >> ELEM_WIDTH;
                    elem_d  = elem_q + 1'b1;
                    row_d   = (row_q == LAST_COL) ? '0 : row_q + 1'b1;
                    if (elem_q == LAST_ELEM) begin
                        if (word_q == LAST_WORD) begin
                            state_d = S_DONE;
                        end else begin
                            word_d  = word_q + 1'b1;
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ofm_drain_streamer.sv
// Randomized self-checking bench for ofm_drain_streamer against a frame-level reference model.
module tb_ofm_drain_streamer;
    localparam int IW = 128, EW = 16, AW = 11, FW = 2, ROW = 8;
    localparam int EPW = IW / EW, TOTAL = FW * EPW, BOUND = 300, DEPTH = 1 << AW;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, m_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic ofm_re_b, m_valid, m_last_row, m_last_frame, busy, done;
    logic [AW-1:0] ofm_addr_b;
    logic [IW-1:0] ofm_dout_b = '0;
    logic [EW-1:0] m_data;
    logic [IW-1:0] ram [0:DEPTH-1];

    int checks = 0, failures = 0;
    logic [EW-1:0] got_data[$], exp_data[$];
    logic          got_row[$], exp_row[$], got_frame[$], exp_frame[$];
    logic [AW-1:0] got_addr[$], exp_addr[$];
    int done_cnt, done_cyc, first_valid, last_hs, stab_err;

    ofm_drain_streamer #(.INOUT_WIDTH(IW), .ELEM_WIDTH(EW), .ADDR_WIDTH(AW),
                         .FRAME_WORDS(FW), .ROW_ELEMS(ROW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .ofm_re_b(ofm_re_b), .ofm_addr_b(ofm_addr_b), .ofm_dout_b(ofm_dout_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last_row(m_last_row), .m_last_frame(m_last_frame), .busy(busy), .done(done));

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency; the data bus carries junk when not reading.
    always @(posedge clk) begin
        if (ofm_re_b) ofm_dout_b <= ram[ofm_addr_b];
        else          ofm_dout_b <= {$urandom, $urandom, $urandom, $urandom};
    end

    task automatic fill_random(input logic [AW-1:0] base);
        for (int w = 0; w < FW; w++)
            ram[(int'(base) + w) % DEPTH] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic build_expected(input logic [AW-1:0] base);
        logic [AW-1:0] a;
        logic [EW-1:0] e;
        int k;
        k = 0;
        exp_data.delete(); exp_row.delete(); exp_frame.delete(); exp_addr.delete();
        for (int w = 0; w < FW; w++) begin
            a = AW'((int'(base) + w) % DEPTH);
            exp_addr.push_back(a);
            for (int i = 0; i < EPW; i++) begin
                e = ram[a][i*EW +: EW];
`ifdef OFM_DRAIN_RELU_EN
                if ($signed(e) < 0) e = '0;
`endif
                exp_data.push_back(e);
                exp_row.push_back((k % ROW) == ROW - 1);
                exp_frame.push_back(k == TOTAL - 1);
                k++;
            end
        end
    endtask

    // Runs one frame, recording reads, handshakes, done pulses and hold-stability violations.
    task automatic drain(input logic [AW-1:0] base, input int rmode, input bit repulse);
        int cyc;
        bit hold;
        logic [EW+1:0] held;
        got_data.delete(); got_row.delete(); got_frame.delete(); got_addr.delete();
        done_cnt = 0; done_cyc = -1; first_valid = -1; last_hs = -1; stab_err = 0;
        hold = 1'b0; held = '0;
        @(negedge clk);
        base_addr = base; start = 1'b1; m_ready = 1'b0;
        cyc = 0;
        while (cyc < BOUND && !(done_cyc >= 0 && cyc > done_cyc + 4)) begin
            @(negedge clk);
            cyc++;
            start = repulse && (cyc == 4 || cyc == 12);
            if (repulse) base_addr = base + AW'(11'h155);
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2) == 1;
                default: m_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (ofm_re_b) got_addr.push_back(ofm_addr_b);
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (hold && (!m_valid || {m_data, m_last_row, m_last_frame} !== held)) stab_err++;
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
            if (m_valid && m_ready) begin
                got_data.push_back(m_data); got_row.push_back(m_last_row);
                got_frame.push_back(m_last_frame); last_hs = cyc;
            end
            hold = m_valid && !m_ready;
            held = {m_data, m_last_row, m_last_frame};
        end
        start = 1'b0; m_ready = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        @(negedge clk);
        checks++;
        if ({m_valid, busy, done, ofm_re_b, ofm_addr_b, m_data, m_last_row, m_last_frame} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h want=0",
                {m_valid, busy, done, ofm_re_b, ofm_addr_b, m_data, m_last_row, m_last_frame});
        end
        rst = 1'b0;
        fill_random(11'h040);
        @(negedge clk); base_addr = 11'h040; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!m_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (m_valid !== 1'b1) begin failures++; $display("FAIL reset_reach_emit got=%b want=1", m_valid); end
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_valid, busy, done, ofm_re_b} !== 4'b0) begin
            failures++; $display("FAIL reset_mid_emit got=%b want=0000", {m_valid, busy, done, ofm_re_b});
        end
        checks++;
        if ({m_data, m_last_row, m_last_frame, ofm_addr_b} !== '0) begin
            failures++; $display("FAIL reset_mid_data got=%h want=0", {m_data, m_last_row, m_last_frame, ofm_addr_b});
        end
        @(negedge clk); rst = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (done || busy || m_valid) n++; end
        checks++;
        if (n !== 0) begin failures++; $display("FAIL reset_no_resume got=%0d want=0", n); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < EPW; i++) begin
            ram[11'h010][i*EW +: EW] = EW'(i);
            ram[11'h011][i*EW +: EW] = EW'(i + EPW);
        end
        build_expected(11'h010);
        drain(11'h010, 0, 1'b0);
        checks++;
        if (got_data.size() !== TOTAL) begin failures++; $display("FAIL basic_count got=%0d want=%0d", got_data.size(), TOTAL); end
        for (int i = 0; i < TOTAL && i < got_data.size(); i++) begin
            checks++;
            if ({got_data[i], got_row[i], got_frame[i]} !== {EW'(i), (i % ROW) == ROW - 1, i == TOTAL - 1}) begin
                failures++; $display("FAIL basic_elem[%0d] got=%h/%b/%b want=%h", i, got_data[i], got_row[i], got_frame[i], i);
            end
        end
        checks++;
        if (got_addr !== exp_addr) begin failures++; $display("FAIL basic_addr got=%p want=%p", got_addr, exp_addr); end
        checks++;
        if (first_valid !== 3) begin failures++; $display("FAIL basic_latency got=%0d want=3", first_valid); end
        checks++;
        if (last_hs !== 3 + TOTAL + 2 * (FW - 1) - 1) begin
            failures++; $display("FAIL basic_gap got=%0d want=%0d", last_hs, 3 + TOTAL + 2 * (FW - 1) - 1);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== last_hs + 1) begin
            failures++; $display("FAIL basic_done got=%0d@%0d want=1@%0d", done_cnt, done_cyc, last_hs + 1);
        end
    endtask

    task automatic test_backpressure();
        build_expected(11'h010);
        drain(11'h010, 1, 1'b0);
        checks++;
        if (got_data !== exp_data || got_row !== exp_row || got_frame !== exp_frame) begin
            failures++; $display("FAIL bp_stream got=%p want=%p", got_data, exp_data);
        end
        checks++;
        if (stab_err !== 0) begin failures++; $display("FAIL bp_stable got=%0d want=0", stab_err); end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL bp_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_wrap();
        fill_random(11'h7FF);
        build_expected(11'h7FF);
        drain(11'h7FF, 2, 1'b0);
        checks++;
        if (got_addr.size() !== 2 || got_addr[0] !== 11'h7FF || got_addr[1] !== 11'h000) begin
            failures++; $display("FAIL wrap_addr got=%p want=7ff,000", got_addr);
        end
        checks++;
        if (got_data !== exp_data || got_frame !== exp_frame) begin
            failures++; $display("FAIL wrap_stream got=%p want=%p", got_data, exp_data);
        end
    endtask

    task automatic test_restart();
        fill_random(11'h100);
        build_expected(11'h100);
        drain(11'h100, 2, 1'b1);
        checks++;
        if (got_addr !== exp_addr) begin failures++; $display("FAIL restart_addr got=%p want=%p", got_addr, exp_addr); end
        checks++;
        if (done_cnt !== 1) begin failures++; $display("FAIL restart_done got=%0d want=1", done_cnt); end
        checks++;
        if (got_data !== exp_data || stab_err !== 0) begin
            failures++; $display("FAIL restart_stream got=%p/%0d want=%p/0", got_data, stab_err, exp_data);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL restart_idle got=%b want=0", busy); end
    endtask

    task automatic test_relu();
        logic [EW-1:0] want_neg;
`ifdef OFM_DRAIN_RELU_EN
        want_neg = 16'h0000;
`else
        want_neg = 16'hFF85;
`endif
        fill_random(11'h020);
        ram[11'h020][0*EW +: EW] = 16'hFF85;
        ram[11'h020][1*EW +: EW] = 16'h0042;
        ram[11'h020][2*EW +: EW] = 16'h8000;
        ram[11'h020][3*EW +: EW] = 16'h7FFF;
        build_expected(11'h020);
        drain(11'h020, 2, 1'b0);
        checks++;
        if (got_data.size() < 2 || got_data[0] !== want_neg) begin
            failures++; $display("FAIL relu_neg got=%p want=%h first", got_data, want_neg);
        end
        checks++;
        if (got_data.size() < 2 || got_data[1] !== 16'h0042) begin
            failures++; $display("FAIL relu_pos got=%p want=0042 second", got_data);
        end
        checks++;
        if (got_data !== exp_data) begin failures++; $display("FAIL relu_stream got=%p want=%p", got_data, exp_data); end
    endtask

    task automatic test_random();
        logic [AW-1:0] b;
        for (int f = 0; f < 4; f++) begin
            b = AW'($urandom_range(0, DEPTH - 1));
            fill_random(b);
            build_expected(b);
            drain(b, $urandom_range(0, 2), f[0]);
            checks++;
            if (got_data !== exp_data || got_row !== exp_row || got_frame !== exp_frame || got_addr !== exp_addr) begin
                failures++; $display("FAIL rand_frame%0d got=%p want=%p", f, got_data, exp_data);
            end
            checks++;
            if (done_cnt !== 1 || done_cyc !== last_hs + 1 || stab_err !== 0 || first_valid !== 3) begin
                failures++; $display("FAIL rand_ctrl%0d got=done%0d@%0d stab%0d lat%0d want=1@%0d 0 3",
                    f, done_cnt, done_cyc, stab_err, first_valid, last_hs + 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_restart();
        test_relu();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
